// File: rtl/pwm_core.sv
// -----------------------------------------------------------------------------
// pwm_core
// Timing engine of the pwm_generator peripheral. Takes decoded register values
// from the AXI4-Lite register file and produces a complementary PWM pair with
// dead-time insertion plus a one-cycle interrupt pulse at every period end.
// Register writes are double-buffered: they land in a staging set and are
// promoted to the active set only on a period boundary (or at once when idle).
//
// Ports:
//   ACLK          system clock, rising edge
//   ARESET        asynchronous active-high reset
//   cfg_enable    run request (level)
//   cfg_polarity  0: active-high outputs, 1: active-low outputs
//   cfg_period    terminal count, period = cfg_period + 1 cycles
//   cfg_duty      high-side on-time in cycles
//   cfg_deadtime  dead-time cycles inserted before either output turns on
//   cfg_load      one-cycle strobe capturing period/duty/deadtime/polarity
//   pwm_h, pwm_l  high-side / low-side outputs
//   period_irq    one-cycle pulse following each terminal count
//   sts_running   FSM is in RUN
//   sts_pending   staged values are waiting for a period boundary
// -----------------------------------------------------------------------------
module pwm_core #(
    parameter int CNT_WIDTH = 16,
    parameter int DT_WIDTH  = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 cfg_enable,
    input  logic                 cfg_polarity,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_duty,
    input  logic [DT_WIDTH-1:0]  cfg_deadtime,
    input  logic                 cfg_load,
    output logic                 pwm_h,
    output logic                 pwm_l,
    output logic                 period_irq,
    output logic                 sts_running,
    output logic                 sts_pending
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   run_active;
    logic                   tc;
    logic                   raw_next;
    logic                   h_on;
    logic                   l_on;

    logic [CNT_WIDTH-1:0]   cnt;
    logic                   raw;
    logic [DT_WIDTH-1:0]    dt_cnt;
    logic                   pending;

    logic [CNT_WIDTH-1:0]   period_stg;
    logic [CNT_WIDTH-1:0]   duty_stg;
    logic [DT_WIDTH-1:0]    dt_stg;
    logic                   pol_stg;

    logic [CNT_WIDTH-1:0]   period_act;
    logic [CNT_WIDTH-1:0]   duty_act;
    logic [DT_WIDTH-1:0]    dt_act;
    logic                   pol_act;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // run_active is only true in RUN while enable is still held, so dropping
    // enable stops the counter and forces outputs inactive on the very next edge.
    always_comb begin
        state_next = state;
        run_active = 1'b0;
        tc         = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                run_active = cfg_enable;
                tc         = cfg_enable && (cnt == period_act);
                if (!cfg_enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Period counter only wraps through the terminal count, so an all-ones
    // period still gives 2^CNT_WIDTH cycles without relying on overflow.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt        <= '0;
            period_irq <= 1'b0;
        end else begin
            period_irq <= tc;
            if (!run_active || tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    // A load that coincides with the terminal count bypasses staging so the
    // new values govern the period that starts on the next cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pending    <= 1'b0;
            period_stg <= '0;
            duty_stg   <= '0;
            dt_stg     <= '0;
            pol_stg    <= 1'b0;
            period_act <= '0;
            duty_act   <= '0;
            dt_act     <= '0;
            pol_act    <= 1'b0;
        end else if (cfg_load && tc) begin
            period_act <= cfg_period;
            duty_act   <= cfg_duty;
            dt_act     <= cfg_deadtime;
            pol_act    <= cfg_polarity;
            pending    <= 1'b0;
        end else begin
            if (pending && (tc || state == IDLE)) begin
                period_act <= period_stg;
                duty_act   <= duty_stg;
                dt_act     <= dt_stg;
                pol_act    <= pol_stg;
                pending    <= 1'b0;
            end
            if (cfg_load) begin
                period_stg <= cfg_period;
                duty_stg   <= cfg_duty;
                dt_stg     <= cfg_deadtime;
                pol_stg    <= cfg_polarity;
                pending    <= 1'b1;
            end
        end
    end

    assign raw_next = run_active && (cnt < duty_act);

    // dt_cnt holds how many cycles raw has kept its current value (saturating).
    // It is cleared while stopped so both sides observe the dead time on start.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            raw    <= 1'b0;
            dt_cnt <= '0;
        end else begin
            raw <= raw_next;
            if (!run_active || (raw_next != raw)) begin
                dt_cnt <= '0;
            end else if (dt_cnt != '1) begin
                dt_cnt <= dt_cnt + DT_WIDTH'(1);
            end
        end
    end

    assign h_on = run_active &&  raw && (dt_cnt >= dt_act);
    assign l_on = run_active && !raw && (dt_cnt >= dt_act);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else begin
            pwm_h <= h_on ^ pol_act;
            pwm_l <= l_on ^ pol_act;
        end
    end

    assign sts_running = (state == RUN);
    assign sts_pending = pending;

endmodule

// File: tb/tb_pwm_core.sv
// -----------------------------------------------------------------------------
// tb_pwm_core
// Self-checking bench for pwm_core. The stimulus process pushes expected
// output values, tagged with the clock cycle they belong to, into a queue;
// a monitor on the falling edge pops every entry due for the current cycle
// and compares it against the DUT.
// -----------------------------------------------------------------------------
module tb_pwm_core;

    localparam int CW = 16;
    localparam int DW = 8;

    logic          tb_ACLK = 1'b0;
    logic          tb_ARESET;
    logic          cfg_enable;
    logic          cfg_polarity;
    logic [CW-1:0] cfg_period;
    logic [CW-1:0] cfg_duty;
    logic [DW-1:0] cfg_deadtime;
    logic          cfg_load;
    logic          pwm_h;
    logic          pwm_l;
    logic          period_irq;
    logic          sts_running;
    logic          sts_pending;

    pwm_core #(.CNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
        .ACLK         (tb_ACLK),
        .ARESET       (tb_ARESET),
        .cfg_enable   (cfg_enable),
        .cfg_polarity (cfg_polarity),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_deadtime (cfg_deadtime),
        .cfg_load     (cfg_load),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .period_irq   (period_irq),
        .sts_running  (sts_running),
        .sts_pending  (sts_pending)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    int cyc = 0;
    always @(posedge tb_ACLK) cyc <= cyc + 1;

    typedef enum int {SIG_H, SIG_L, SIG_IRQ, SIG_RUN, SIG_PEND} sig_t;
    typedef struct {
        int    cyc;
        sig_t  sig;
        logic  val;
        string name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%b expected=%b", name, cyc, actual, expected);
        end
    endtask

    function automatic logic sample(input sig_t s);
        case (s)
            SIG_H:    return pwm_h;
            SIG_L:    return pwm_l;
            SIG_IRQ:  return period_irq;
            SIG_RUN:  return sts_running;
            SIG_PEND: return sts_pending;
            default:  return 1'bx;
        endcase
    endfunction

    task automatic push_exp(input int c, input sig_t s, input logic v, input string n);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endtask

    always @(negedge tb_ACLK) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc != cyc) begin
                total++;
                bad++;
                $display("[TB] FAIL %s late: due cycle=%0d checked cycle=%0d", mon_e.name, mon_e.cyc, cyc);
            end else begin
                checkOutput(mon_e.name, sample(mon_e.sig), mon_e.val);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge tb_ACLK);
        #1;
    endtask

    task automatic wait_until(input int t);
        if (cyc < t) tick(t - cyc);
    endtask

    // One-cycle register-write strobe carrying a complete configuration.
    task automatic applyStimulus(input int period, input int duty, input int dt, input logic pol);
        cfg_period   = CW'(period);
        cfg_duty     = CW'(duty);
        cfg_deadtime = DW'(dt);
        cfg_polarity = pol;
        cfg_load     = 1'b1;
        tick(1);
        cfg_load     = 1'b0;
    endtask

    // Stop, load a configuration while idle, then raise enable. Returns the
    // cycle k on which enable is driven; the DUT is in RUN from cycle k+1.
    task automatic start_run(input int period, input int duty, input int dt, input logic pol,
                             input string tag, output int k);
        cfg_enable = 1'b0;
        tick(1);
        applyStimulus(period, duty, dt, pol);
        push_exp(cyc,     SIG_PEND, 1'b1, {tag, "_pend_idle_set"});
        push_exp(cyc + 1, SIG_PEND, 1'b0, {tag, "_pend_idle_clr"});
        tick(2);
        cfg_enable = 1'b1;
        k = cyc;
        push_exp(k,     SIG_RUN, 1'b0, {tag, "_run_idle"});
        push_exp(k,     SIG_H,   pol,  {tag, "_h_idle"});
        push_exp(k,     SIG_L,   pol,  {tag, "_l_idle"});
        push_exp(k + 1, SIG_RUN, 1'b1, {tag, "_run_on"});
        push_exp(k + 1, SIG_H,   pol,  {tag, "_h_first"});
        push_exp(k + 1, SIG_L,   pol,  {tag, "_l_first"});
    endtask

    initial begin
        automatic int k;
        automatic int d;
        automatic logic h;

        tb_ARESET    = 1'b0;
        cfg_enable   = 1'b0;
        cfg_polarity = 1'b0;
        cfg_period   = '0;
        cfg_duty     = '0;
        cfg_deadtime = '0;
        cfg_load     = 1'b0;
        #2 tb_ARESET = 1'b1;
        tick(2);
        checkOutput("rst_h",    pwm_h,       1'b0);
        checkOutput("rst_l",    pwm_l,       1'b0);
        checkOutput("rst_irq",  period_irq,  1'b0);
        checkOutput("rst_run",  sts_running, 1'b0);
        checkOutput("rst_pend", sts_pending, 1'b0);
        tb_ARESET = 1'b0;
        tick(2);

        // Basic 30% waveform, no dead time; first pwm_h rise at k+3.
        start_run(9, 3, 0, 1'b0, "t2", k);
        push_exp(k + 2, SIG_H,   1'b0, "t2_h_lat");
        push_exp(k + 2, SIG_L,   1'b1, "t2_l_lat");
        push_exp(k + 1, SIG_IRQ, 1'b0, "t2_irq_early");
        push_exp(k + 2, SIG_IRQ, 1'b0, "t2_irq_early");
        for (int m = 0; m < 20; m++) begin
            h = (m % 10) < 3;
            push_exp(k + 3 + m, SIG_H,   h,              "t2_h");
            push_exp(k + 3 + m, SIG_L,   !h,             "t2_l");
            push_exp(k + 3 + m, SIG_IRQ, (m % 10) == 8,  "t2_irq");
        end
        wait_until(k + 23);

        // Dead time 2 with duty 5: each side on for 3 cycles, two 2-cycle gaps.
        start_run(9, 5, 2, 1'b0, "t3", k);
        for (int m = 0; m < 20; m++) begin
            push_exp(k + 3 + m, SIG_H, (m % 10) >= 2 && (m % 10) <= 4, "t3_h");
            push_exp(k + 3 + m, SIG_L, (m % 10) >= 7,                  "t3_l");
        end
        wait_until(k + 23);

        // Mid-period load is deferred to the boundary; a load on the TC cycle
        // applies to the very next period with no pending phase.
        start_run(9, 3, 0, 1'b0, "t4", k);
        for (int m = 0; m < 40; m++) begin
            d = (m < 10) ? 3 : ((m < 30) ? 7 : 5);
            push_exp(k + 3 + m, SIG_H, (m % 10) < d, "t4_h");
        end
        push_exp(k + 5,  SIG_PEND, 1'b0, "t4_pend_before");
        push_exp(k + 6,  SIG_PEND, 1'b1, "t4_pend_set");
        push_exp(k + 10, SIG_PEND, 1'b1, "t4_pend_hold");
        push_exp(k + 11, SIG_PEND, 1'b0, "t4_pend_clr");
        push_exp(k + 31, SIG_PEND, 1'b0, "t4_pend_tc_load");
        push_exp(k + 32, SIG_PEND, 1'b0, "t4_pend_tc_load");
        push_exp(k + 31, SIG_IRQ,  1'b1, "t4_irq");
        wait_until(k + 5);
        applyStimulus(9, 7, 0, 1'b0);
        wait_until(k + 30);
        applyStimulus(9, 5, 0, 1'b0);
        wait_until(k + 43);

        // duty 0: never on.
        start_run(9, 0, 0, 1'b0, "t5a", k);
        for (int m = 0; m < 20; m++) begin
            push_exp(k + 3 + m, SIG_H, 1'b0, "t5a_h");
            push_exp(k + 3 + m, SIG_L, 1'b1, "t5a_l");
        end
        wait_until(k + 23);

        // duty beyond period: constantly on.
        start_run(9, 12, 0, 1'b0, "t5b", k);
        for (int m = 0; m < 20; m++) begin
            push_exp(k + 3 + m, SIG_H, 1'b1, "t5b_h");
            push_exp(k + 3 + m, SIG_L, 1'b0, "t5b_l");
        end
        wait_until(k + 23);

        // period 0: terminal count every cycle.
        start_run(0, 1, 0, 1'b0, "t5c", k);
        for (int t = 2; t < 22; t++) begin
            push_exp(k + t, SIG_IRQ, 1'b1, "t5c_irq");
            if (t >= 3) push_exp(k + t, SIG_H, 1'b1, "t5c_h");
        end
        wait_until(k + 22);

        // pulse shorter than dead time: high side never asserts.
        start_run(9, 1, 3, 1'b0, "t5d", k);
        for (int m = 0; m < 20; m++) begin
            push_exp(k + 3 + m, SIG_H, 1'b0,           "t5d_h");
            push_exp(k + 3 + m, SIG_L, (m % 10) >= 4,  "t5d_l");
        end
        wait_until(k + 23);

        // Active-low outputs, then an immediate stop mid-period.
        start_run(9, 3, 0, 1'b1, "t6", k);
        for (int m = 0; m < 14; m++) begin
            h = (m % 10) < 3;
            push_exp(k + 3 + m, SIG_H, !h, "t6_h");
            push_exp(k + 3 + m, SIG_L, h,  "t6_l");
        end
        push_exp(k + 16, SIG_RUN, 1'b1, "t6_run_before_stop");
        push_exp(k + 17, SIG_RUN, 1'b0, "t6_run_stopped");
        for (int t = 17; t < 20; t++) begin
            push_exp(k + t, SIG_H, 1'b1, "t6_h_stopped");
            push_exp(k + t, SIG_L, 1'b1, "t6_l_stopped");
        end
        wait_until(k + 16);
        cfg_enable = 1'b0;
        wait_until(k + 20);

        // Asynchronous reset while pwm_h is active.
        start_run(9, 3, 0, 1'b0, "t1", k);
        wait_until(k + 4);
        checkOutput("t1_h_pre",   pwm_h,       1'b1);
        checkOutput("t1_run_pre", sts_running, 1'b1);
        #1;
        tb_ARESET  = 1'b1;
        cfg_enable = 1'b0;
        #1;
        checkOutput("t1_h_async",    pwm_h,       1'b0);
        checkOutput("t1_l_async",    pwm_l,       1'b0);
        checkOutput("t1_irq_async",  period_irq,  1'b0);
        checkOutput("t1_run_async",  sts_running, 1'b0);
        checkOutput("t1_pend_async", sts_pending, 1'b0);
        tick(2);
        tb_ARESET = 1'b0;
        tick(1);
        start_run(9, 3, 0, 1'b0, "t1post", k);
        for (int m = 0; m < 10; m++) begin
            push_exp(k + 3 + m, SIG_H,   (m % 10) < 3,  "t1post_h");
            push_exp(k + 3 + m, SIG_IRQ, (m % 10) == 8, "t1post_irq");
        end
        wait_until(k + 13);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain remaining=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
